mux8x1_rr_collector: RTL and testbench
======================================

Name: mux8x1_rr_collector

Overview:
- Gathering end of the 1-to-8 distribution path: merges 8 independent valid/ready input channels onto one registered output stream.
- Tags each output beat with its 3-bit source select, so a downstream 1x8 demux can route it back out.
- Arbitration is round-robin with packet locking: once a channel wins, it keeps the output until its last beat.
- Sits between the per-channel producers and the shared serial/bus link.

Parameters:
- DATA_W, 8, width of each channel's data beat.
- NUM_CH, 8, number of input channels. Fixed at 8; the select width is tied to it.
- SEL_W, 3, width of the channel select/tag (log2 NUM_CH).

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  8  per-channel beat valid.
- in_data  input  8*DATA_W  packed channel data; channel k occupies bits [k*DATA_W +: DATA_W].
- in_last  input  8  per-channel end-of-packet flag, qualified by in_valid.
- in_ready  output  8  per-channel accept. At most one bit is high at any time (one-hot or zero).
- out_valid  output  1  output register holds a beat.
- out_data  output  DATA_W  registered beat data.
- out_sel  output  SEL_W  source channel of the current beat.
- out_last  output  1  registered copy of the source in_last.
- out_ready  input  1  downstream accept.

Behaviour:
- Reset (async assert, sync release):
  - out_valid=0, out_data=0, out_sel=0, out_last=0.
  - Round-robin pointer ptr=0; FSM=ARB; lock channel lch=0.
  - in_ready=0 throughout reset.
- Load condition: load_ok = !out_valid | out_ready. This gives a single register stage with full throughput: one beat per cycle when out_ready is held high.
- FSM ARB:
  - If load_ok, choose g = first k with in_valid[k], searching ptr, ptr+1, ... modulo 8.
  - in_ready[g]=1 combinationally in the same cycle.
  - On the clock edge: out_data, out_sel=g and out_last are captured; out_valid=1.
  - If in_last[g]=0, go to LOCKED with lch=g. Otherwise stay in ARB and set ptr=g+1 (mod 8, wraps 7->0).
  - If no channel is valid, or load_ok=0, then in_ready=0 and no state change. out_valid drops to 0 only if the old beat was taken and nothing was loaded.
- FSM LOCKED:
  - Only channel lch is eligible. in_ready[lch] = load_ok.
  - Other channels are ignored even when they are valid.
  - A transfer with in_last[lch]=1 returns the FSM to ARB and sets ptr=lch+1.
  - A stalled or idle locked channel holds the lock indefinitely. There is no timeout.
- Latency: input handshake to out_valid is 1 cycle.
- Output stability: out_data, out_sel and out_last are stable while out_valid=1 and out_ready=0.
- in_ready never depends on a channel's own in_valid except through the grant search. There is no combinational path from out_ready to out_valid.
- Fairness: a continuously valid channel waits at most 7 packets.
- Reset mid-packet: the lock is dropped, the held beat is discarded, and arbitration restarts at channel 0.
- Simultaneous events: unload and load in the same cycle replace the register contents with no bubble. The FSM and ptr update use the granted beat's in_last.

Decomposition:
- Shared package mux_demux_pkg:
  - NUM_CH, SEL_W, DATA_W default.
  - FSM state type {ARB, LOCKED}.
  - Helper function rr_next(ptr, req) returning {found, grant}.
- One natural sub-module: rr_arbiter8 (8-bit request, 3-bit pointer in, one-hot grant plus encoded index out, purely combinational). The top level holds the FSM, pointer and output register.

Test Plan:
- Reset release with all in_valid=0 -> out_valid=0 and in_ready=0 for 10 cycles; outputs all zero.
- in_valid=8'hFF, all in_last=1, out_ready=1 held -> out_sel sequence 0,1,2,...,7,0 with one beat per cycle; each in_ready is one-hot matching the next out_sel.
- Ch5 sends a 3-beat packet (last on beat 3) while ch2 and ch6 are valid throughout -> out_sel=5,5,5, then 6, then 2; no interleave during the packet.
- out_ready=0 for 4 cycles with ch1 valid, then 1 -> out_data and out_sel held constant; in_ready[1]=0 while stalled; the beat transfers once ready returns, with no duplication or loss.
- ptr=7 with only ch7 and ch0 valid, single-beat packets -> grants 7 then 0 (wrap); ptr becomes 1.
- rst_n pulsed low mid-packet on ch3 -> out_valid goes to 0 immediately (async); after release, ch1 valid is granted even though ch3 had the lock.

Source files
------------

// File: rtl/mux_demux_pkg.sv
// mux_demux_pkg: shared constants, FSM state type and round-robin helpers
// for the 1x8 distribution / 8x1 collection path.
package mux_demux_pkg;
    localparam int NUM_CH     = 8;
    localparam int SEL_W      = 3;
    localparam int DATA_W_DEF = 8;

    typedef enum logic {ARB, LOCKED} state_e;

    function automatic logic [NUM_CH-1:0] sel2oh(input logic [SEL_W-1:0] sel);
        return {{(NUM_CH-1){1'b0}}, 1'b1} << sel;
    endfunction

    // Returns {found, grant}: first requester at or after ptr, wrapping modulo NUM_CH.
    function automatic logic [SEL_W:0] rr_next(input logic [SEL_W-1:0] ptr,
                                               input logic [NUM_CH-1:0] req);
        logic [SEL_W:0]   r;
        logic [SEL_W-1:0] k;
        r = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            k = ptr + SEL_W'(i);
            if (req[k]) r = {1'b1, k};
        end
        return r;
    endfunction
endpackage

// File: rtl/rr_arbiter8.sv
// rr_arbiter8: combinational 8-way round-robin arbiter, one-hot grant plus index.
module rr_arbiter8
    import mux_demux_pkg::*;
(
    input  logic [NUM_CH-1:0] req_i,
    input  logic [SEL_W-1:0]  ptr_i,
    output logic              found_o,
    output logic [SEL_W-1:0]  idx_o,
    output logic [NUM_CH-1:0] gnt_o
);
    always_comb begin
        {found_o, idx_o} = rr_next(ptr_i, req_i);
        gnt_o = found_o ? sel2oh(idx_o) : '0;
    end
endmodule

// File: rtl/mux8x1_rr_collector.sv
// mux8x1_rr_collector: merges 8 valid/ready channels onto one registered output
// stream tagged with its source, round-robin arbitrated with per-packet locking.
module mux8x1_rr_collector
    import mux_demux_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_CH-1:0]        in_valid,
    input  logic [NUM_CH*DATA_W-1:0] in_data,
    input  logic [NUM_CH-1:0]        in_last,
    output logic [NUM_CH-1:0]        in_ready,
    output logic                     out_valid,
    output logic [DATA_W-1:0]        out_data,
    output logic [SEL_W-1:0]         out_sel,
    output logic                     out_last,
    input  logic                     out_ready
);
    state_e             state_q, state_d;
    logic [SEL_W-1:0]   ptr_q, ptr_d, lch_q, lch_d;
    logic               out_valid_q, out_valid_d, out_last_q, out_last_d;
    logic [DATA_W-1:0]  out_data_q, out_data_d;
    logic [SEL_W-1:0]   out_sel_q, out_sel_d;
    logic               arb_found, load_ok, fire;
    logic [SEL_W-1:0]   arb_idx, gidx;
    logic [NUM_CH-1:0]  arb_gnt;

    rr_arbiter8 u_arb (
        .req_i   (in_valid),
        .ptr_i   (ptr_q),
        .found_o (arb_found),
        .idx_o   (arb_idx),
        .gnt_o   (arb_gnt)
    );

    always_comb begin
        load_ok     = !out_valid_q || out_ready;
        in_ready    = '0;
        gidx        = arb_idx;
        fire        = 1'b0;
        state_d     = state_q;
        ptr_d       = ptr_q;
        lch_d       = lch_q;
        out_valid_d = out_valid_q && !out_ready;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        out_last_d  = out_last_q;
        if (state_q == ARB) begin
            fire     = load_ok && arb_found;
            in_ready = fire ? arb_gnt : '0;
        end else begin
            // Locked channel sees ready whenever the register can load, valid or not.
            gidx     = lch_q;
            fire     = load_ok && in_valid[lch_q];
            in_ready = load_ok ? sel2oh(lch_q) : '0;
        end
        if (!rst_n) in_ready = '0;
        if (fire) begin
            out_valid_d = 1'b1;
            out_data_d  = in_data[gidx*DATA_W +: DATA_W];
            out_sel_d   = gidx;
            out_last_d  = in_last[gidx];
            state_d     = in_last[gidx] ? ARB : LOCKED;
            lch_d       = gidx;
            ptr_d       = in_last[gidx] ? gidx + 1'b1 : ptr_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ARB;
            ptr_q       <= '0;
            lch_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            lch_q       <= lch_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
            out_last_q  <= out_last_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;
    assign out_last  = out_last_q;

    a_ready_onehot0: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(in_ready));
endmodule

// File: tb/tb_mux8x1_rr_collector.sv
// tb_mux8x1_rr_collector: table-driven directed checks plus hand-written stall
// and mid-packet reset sequences.
module tb_mux8x1_rr_collector;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  in_valid, in_last, in_ready;
    logic [63:0] in_data;
    logic        out_valid, out_last, out_ready;
    logic [7:0]  out_data;
    logic [2:0]  out_sel;
    int          n_chk = 0;
    int          n_fail = 0;

    typedef struct {
        logic [7:0] v;
        logic [7:0] l;
        logic       ordy;
        logic [7:0] er;
        logic       eov;
        logic [2:0] es;
        logic       el;
    } vec_t;
    vec_t tbl[$];

    mux8x1_rr_collector dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_last  (out_last),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic [7:0] v, input logic [7:0] l, input logic ordy,
                                input logic [7:0] er, input logic eov, input logic [2:0] es,
                                input logic el);
        vec_t r;
        r.v = v; r.l = l; r.ordy = ordy; r.er = er; r.eov = eov; r.es = es; r.el = el;
        return r;
    endfunction

    initial begin
        rst_n = 1'b0; in_valid = '0; in_last = '0; out_ready = 1'b1;
        for (int k = 0; k < 8; k++) in_data[k*8 +: 8] = 8'hA0 + 8'(k);
        // table: round-robin sweep, 3-beat locked packet, pointer wrap
        for (int i = 0; i < 9; i++) tbl.push_back(mk(8'hFF, 8'hFF, 1, 8'h01 << (i % 8), 1, 3'(i % 8), 1));
        tbl.push_back(mk(8'h00, 8'hFF, 1, 8'h00, 0, 0, 0));
        tbl.push_back(mk(8'h10, 8'hFF, 1, 8'h10, 1, 4, 1));
        tbl.push_back(mk(8'h64, 8'h44, 1, 8'h20, 1, 5, 0));
        tbl.push_back(mk(8'h64, 8'h44, 1, 8'h20, 1, 5, 0));
        tbl.push_back(mk(8'h64, 8'h64, 1, 8'h20, 1, 5, 1));
        tbl.push_back(mk(8'h44, 8'h44, 1, 8'h40, 1, 6, 1));
        tbl.push_back(mk(8'h04, 8'hFF, 1, 8'h04, 1, 2, 1));
        tbl.push_back(mk(8'h00, 8'hFF, 1, 8'h00, 0, 0, 0));
        tbl.push_back(mk(8'h40, 8'hFF, 1, 8'h40, 1, 6, 1));
        tbl.push_back(mk(8'h81, 8'hFF, 1, 8'h80, 1, 7, 1));
        tbl.push_back(mk(8'h01, 8'hFF, 1, 8'h01, 1, 0, 1));
        tbl.push_back(mk(8'h00, 8'hFF, 1, 8'h00, 0, 0, 0));
        tbl.push_back(mk(8'h03, 8'hFF, 1, 8'h02, 1, 1, 1));
        tbl.push_back(mk(8'h00, 8'hFF, 1, 8'h00, 0, 0, 0));

        // reset, then 10 idle cycles
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            check("idle_ready", 32'(in_ready), 0);
            check("idle_valid", 32'(out_valid), 0);
            check("idle_out", {out_data, 5'(out_sel), 1'b0, out_last}, 0);
        end

        foreach (tbl[i]) begin
            in_valid = tbl[i].v; in_last = tbl[i].l; out_ready = tbl[i].ordy;
            #1 check($sformatf("vec%0d_ready", i), 32'(in_ready), 32'(tbl[i].er));
            @(posedge clk); #1;
            check($sformatf("vec%0d_ov", i), 32'(out_valid), 32'(tbl[i].eov));
            if (tbl[i].eov) begin
                check($sformatf("vec%0d_sel", i), 32'(out_sel), 32'(tbl[i].es));
                check($sformatf("vec%0d_data", i), 32'(out_data), 32'(8'hA0 + 8'(tbl[i].es)));
                check($sformatf("vec%0d_last", i), 32'(out_last), 32'(tbl[i].el));
            end
        end

        // stall: ch1 beat held 4 cycles under out_ready=0, next beat follows without bubble
        in_valid = 8'h02; in_last = 8'h02; in_data[8 +: 8] = 8'h11; out_ready = 1'b0;
        #1 check("stall_load_ready", 32'(in_ready), 32'h02);
        @(posedge clk); #1;
        check("stall_load", {out_valid, 5'(out_sel), out_data}, {1'b1, 5'd1, 8'h11});
        in_data[8 +: 8] = 8'h22;
        for (int c = 0; c < 4; c++) begin
            #1 check("stall_ready", 32'(in_ready), 0);
            @(posedge clk); #1;
            check("stall_hold", {out_valid, 5'(out_sel), out_data}, {1'b1, 5'd1, 8'h11});
        end
        out_ready = 1'b1;
        #1 check("unstall_ready", 32'(in_ready), 32'h02);
        @(posedge clk); #1;
        check("unstall_next", {out_valid, 5'(out_sel), out_data}, {1'b1, 5'd1, 8'h22});
        in_valid = 8'h00; in_data[8 +: 8] = 8'hA1;
        @(posedge clk); #1;
        check("unstall_drain", 32'(out_valid), 0);

        // reset mid-packet on ch3: lock must be dropped, ch1 granted after release
        in_valid = 8'h08; in_last = 8'h00;
        #1 check("lock_first_ready", 32'(in_ready), 32'h08);
        @(posedge clk); #1;
        check("lock_first", {out_valid, 5'(out_sel)}, {1'b1, 5'd3});
        in_valid = 8'h0A;
        #1 check("lock_excl_ready", 32'(in_ready), 32'h08);
        @(posedge clk); #1;
        check("lock_second", {out_valid, 5'(out_sel)}, {1'b1, 5'd3});
        #2 rst_n = 1'b0; in_last = 8'hFF;
        #1 check("rst_ov", 32'(out_valid), 0);
        check("rst_ready", 32'(in_ready), 0);
        check("rst_sel", 32'(out_sel), 0);
        @(posedge clk); #1 rst_n = 1'b1;
        #1 check("post_rst_ready", 32'(in_ready), 32'h02);
        @(posedge clk); #1;
        check("post_rst_grant", {out_valid, 5'(out_sel), out_data, 7'd0, out_last},
              {1'b1, 5'd1, 8'hA1, 7'd0, 1'b1});
        in_valid = 8'h00;
        @(posedge clk); #1;
        check("final_drain", 32'(out_valid), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
